// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Arbitrates a single shared memory port between an instruction-fetch
//   requester and a data requester. When both ask at once, the side that did
//   not win the previous grant goes next. A granted access waits for
//   mem_ready for up to WAIT_LIMIT cycles. If that wait runs out, the access
//   completes with zero read data and sets the sticky bus_err flag.
//
// Ports
//   clk                     rising-edge clock
//   rst                     asynchronous reset, active low
//   inst_req/addr           instruction-fetch request (read only)
//   inst_rdata/ack          fetch response; ack is a one-cycle pulse
//   data_req/addr/wen/wdata data request (wen = byte enables, 0 = read)
//   data_rdata/ack          data response; ack is a one-cycle pulse
//   mem_req/addr/wen/wdata  shared memory request, registered for the grant
//   mem_rdata/ready         shared memory response
//   stall                   freeze request while any requester is unserved
//   bus_err                 sticky timeout flag, cleared only by reset
module mem_arbiter #(
    parameter int WAIT_LIMIT = 255
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic [31:0] inst_rdata,
    output logic        inst_ack,

    input  logic        data_req,
    input  logic [31:0] data_addr,
    input  logic [3:0]  data_wen,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_ack,

    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wen,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,

    output logic        stall,
    output logic        bus_err
);

    // Wait counter is never narrower than 8 bits, and wide enough for WAIT_LIMIT.
    localparam int CNT_W = ($clog2(WAIT_LIMIT + 1) > 8) ? $clog2(WAIT_LIMIT + 1) : 8;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WAIT_LIMIT);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GNT_I = 2'd1;
    localparam logic [1:0] GNT_D = 2'd2;

    localparam logic LG_I = 1'b0;
    localparam logic LG_D = 1'b1;

    logic [1:0]       state;
    logic             last_grant;
    logic [CNT_W-1:0] wait_cnt;

    logic             inst_elig;
    logic             data_elig;
    logic             pick_d;
    logic             done;
    logic [31:0]      resp_data;

    // A side whose ack is high this cycle is not eligible. This keeps a
    // requester that holds req through its ack from being regranted at once.
    assign inst_elig = inst_req & ~inst_ack;
    assign data_elig = data_req & ~data_ack;

    // D wins if it is the only eligible side, or if both are eligible and I
    // had the previous grant.
    assign pick_d = data_elig & (~inst_elig | (last_grant == LG_I));

    assign stall = inst_elig | data_elig;

    // The access ends on mem_ready or on timeout. A timeout returns zero data.
    assign done      = mem_ready | (wait_cnt == CNT_MAX);
    assign resp_data = mem_ready ? mem_rdata : 32'h0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            last_grant <= LG_I;
            wait_cnt   <= '0;
            mem_req    <= 1'b0;
            mem_addr   <= 32'h0;
            mem_wen    <= 4'h0;
            mem_wdata  <= 32'h0;
            inst_ack   <= 1'b0;
            data_ack   <= 1'b0;
            inst_rdata <= 32'h0;
            data_rdata <= 32'h0;
            bus_err    <= 1'b0;
        end else begin
            inst_ack <= 1'b0;
            data_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (inst_elig | data_elig) begin
                        mem_req  <= 1'b1;
                        wait_cnt <= '0;
                        if (pick_d) begin
                            state      <= GNT_D;
                            last_grant <= LG_D;
                            mem_addr   <= data_addr;
                            mem_wen    <= data_wen;
                            mem_wdata  <= data_wdata;
                        end else begin
                            state      <= GNT_I;
                            last_grant <= LG_I;
                            mem_addr   <= inst_addr;
                            mem_wen    <= 4'h0;
                            mem_wdata  <= 32'h0;
                        end
                    end
                end
                GNT_I, GNT_D: begin
                    if (done) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                        if (!mem_ready) begin
                            bus_err <= 1'b1;
                        end
                        if (state == GNT_I) begin
                            inst_rdata <= resp_data;
                            inst_ack   <= 1'b1;
                        end else begin
                            data_rdata <= resp_data;
                            data_ack   <= 1'b1;
                        end
                    end else begin
                        // wait_cnt is below CNT_MAX here, so it stops at
                        // CNT_MAX and cannot wrap.
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter WAIT_LIMIT, default 255, which is the maximum number of cycles a granted access waits for mem_ready before it times out.
REQ-002 The block SHALL have port clk, input, width 1: the single clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port rst, input, width 1: reset, asynchronous and active-low (0 = reset).
REQ-004 The block SHALL have ports inst_req (in, 1), inst_addr (in, 32), inst_rdata (out, 32) and inst_ack (out, 1), forming the instruction-fetch requester port.
REQ-005 The block SHALL have ports data_req (in, 1), data_addr (in, 32), data_wen (in, 4, byte enables, 0 = read), data_wdata (in, 32), data_rdata (out, 32) and data_ack (out, 1), forming the data requester port.
REQ-006 The block SHALL have ports mem_req (out, 1), mem_addr (out, 32), mem_wen (out, 4), mem_wdata (out, 32), mem_rdata (in, 32) and mem_ready (in, 1), forming the single shared memory port.
REQ-007 The block SHALL have port stall (out, 1), a pipeline freeze request.
REQ-008 The block SHALL have port bus_err (out, 1), a sticky timeout flag.

Function
REQ-009 The FSM SHALL have states IDLE, GNT_I and GNT_D, plus a registered last_grant bit (I/D).
REQ-010 In IDLE, a requester is eligible when its req=1 and its ack=0 in that cycle.
REQ-011 In IDLE, if only one requester is eligible, the FSM SHALL go to that requester's grant state on the next edge.
REQ-012 In IDLE, if both are eligible, the FSM SHALL grant D when last_grant=I and grant I when last_grant=D.
REQ-013 On every grant, last_grant SHALL be updated to the granted side.
REQ-014 On entering a grant state, the block SHALL latch the addr, wen and wdata of the granted requester into registers that drive mem_addr/mem_wen/mem_wdata for the whole grant.
REQ-015 For GNT_I, the block SHALL drive mem_wen=4'b0000 and mem_wdata=0.
REQ-016 mem_req SHALL be 1 exactly while in GNT_I or GNT_D and SHALL be registered (no combinational path from any input).
REQ-017 In a grant state with mem_ready=1, the block SHALL register mem_rdata into the granted side's rdata on that edge and pulse that side's ack for exactly one cycle.
REQ-018 In the same case as REQ-017, the FSM SHALL return to IDLE; the ack cycle coincides with the first IDLE cycle.
REQ-019 Minimum latency SHALL be: req seen in IDLE at cycle 0, mem_req at cycle 1, mem_ready at cycle 1, ack/rdata valid at cycle 2.
REQ-020 For writes (wen≠0), rdata SHALL still be updated with mem_rdata, and requesters ignore that value.
REQ-021 rdata of each side SHALL hold its value until that side's next ack.
REQ-022 A wait counter SHALL clear on grant entry and increment each grant cycle with mem_ready=0.
REQ-023 When the wait counter reaches WAIT_LIMIT with mem_ready=0, the block SHALL ack the granted side with rdata=32'h0, set bus_err=1 and go to IDLE.
REQ-024 bus_err SHALL stay 1 until reset.
REQ-025 stall SHALL equal (inst_req & ~inst_ack) | (data_req & ~data_ack), combinationally from inputs and registered acks.
REQ-026 Requesters hold req, addr, wen and wdata stable until they see ack; changes to requester inputs during a grant SHALL NOT affect the memory port.
REQ-027 A requester still asserting req in its ack cycle SHALL NOT be regranted in that cycle and becomes eligible in the next cycle.
REQ-028 The wait counter SHALL be at least 8 bits and SHALL NOT wrap; it saturates at WAIT_LIMIT.

Reset
REQ-029 While rst=0, all of the following SHALL be held asynchronously: state=IDLE, last_grant=I, mem_req=0, mem_addr/mem_wen/mem_wdata=0, inst_ack=data_ack=0, inst_rdata=data_rdata=0, wait counter=0, bus_err=0.
REQ-030 Reset asserted mid-grant SHALL drop mem_req immediately and abandon the access with no ack.
REQ-031 After rst rises, the first edge SHALL evaluate IDLE normally.

Verification
REQ-032 Fetch only: inst_req=1, inst_addr=32'hBFC00000, mem_ready=1 with mem_rdata=32'h24080001 at cycle 1 -> mem_addr=32'hBFC00000, mem_wen=0 at cycle 1; inst_ack=1 and inst_rdata=32'h24080001 at cycle 2; stall low from cycle 2 once inst_req drops.
REQ-033 Simultaneous requests after reset: data_wen=4'b1111, data_addr=32'h10, data_wdata=32'hDEADBEEF -> GNT_D first with mem_wdata=32'hDEADBEEF; GNT_I follows after data_ack; stall high until inst_ack.
REQ-034 Both requesters continuously re-requesting for 8 accesses -> grant order D,I,D,I,D,I,D,I; no two consecutive grants to the same side.
REQ-035 Byte write data_wen=4'b0011 with mem_ready delayed 3 cycles -> mem_wen=4'b0011 stable for 4 grant cycles, mem_req=1 throughout, data_ack exactly one cycle.
REQ-036 Timeout: WAIT_LIMIT=4, mem_ready held 0 -> ack after the counter reaches 4, rdata=0, bus_err=1 and still 1 after 100 further clean accesses.
REQ-037 rst dropped to 0 during GNT_D -> mem_req=0 and all outputs zero before the next clk edge; no data_ack after release; the pending data_req is regranted.
